// File: rtl/data_mem_mmio.sv
// Purpose : data-side memory stage for the single-cycle MIPS core. It holds a word RAM plus
//           memory-mapped GPIO and a 32-bit compare timer.
// Latency : loads are combinational (0 cycles). Stores and register writes take effect on the store edge.
// Backpressure: none; the stage accepts one access every cycle.
// Ports   : clk/rst (sync, active-high); Addr/WriteData/MemWrite from the core;
//           ReadData to the core; gpio_in (async) / gpio_out; timer_irq (registered flag).
module data_mem_mmio #(
  parameter int width = 32,
  parameter int DEPTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [width-1:0] Addr,
  input  logic [width-1:0] WriteData,
  input  logic             MemWrite,
  output logic [width-1:0] ReadData,
  input  logic [7:0]       gpio_in,
  output logic [7:0]       gpio_out,
  output logic             timer_irq
);

  localparam int               AW        = $clog2(DEPTH);
  localparam logic [width-1:0] RAM_BYTES = width'(DEPTH * 4);
  localparam logic [width-1:0] A_GPIO_O  = width'(32'hFFFF_FF00);
  localparam logic [width-1:0] A_GPIO_I  = width'(32'hFFFF_FF04);
  localparam logic [width-1:0] A_COUNT   = width'(32'hFFFF_FF08);
  localparam logic [width-1:0] A_CMP     = width'(32'hFFFF_FF0C);
  localparam logic [width-1:0] A_CTRL    = width'(32'hFFFF_FF10);

  logic [width-1:0] r_mem [DEPTH];
  logic [7:0]       r_gpio_out;
  logic [7:0]       r_sync1;
  logic [7:0]       r_sync2;
  logic [width-1:0] r_count;
  logic [width-1:0] r_cmp;
  logic             r_en;
  logic             r_auto;
  logic             r_flag;

  logic             w_wr;
  logic             w_ram_hit;
  logic [AW-1:0]    w_idx;
  logic             w_match;
  logic [1:0]       w_addr_lo;

  // Byte lanes are ignored: accesses are always whole words.
  assign w_addr_lo = Addr[1:0];
  assign w_wr      = MemWrite & ~rst;
  assign w_ram_hit = (Addr < RAM_BYTES);
  assign w_idx     = Addr[AW+1:2];
  // The match uses the pre-write EN, so a CTRL write only affects later edges.
  assign w_match   = r_en && (r_count == r_cmp);

  // The RAM has no reset, so its contents survive rst.
  always_ff @(posedge clk) begin
    if (w_wr && w_ram_hit) begin
      r_mem[w_idx] <= WriteData;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_gpio_out <= '0;
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_count    <= '0;
      r_cmp      <= '1;
      r_en       <= 1'b0;
      r_auto     <= 1'b0;
      r_flag     <= 1'b0;
    end else begin
      r_sync1 <= gpio_in;
      r_sync2 <= r_sync1;

      // A CPU write to COUNT beats both the increment and the auto-reload.
      if (MemWrite && Addr == A_COUNT) begin
        r_count <= WriteData;
      end else if (r_en) begin
        if (w_match && r_auto) begin
          r_count <= '0;
        end else begin
          r_count <= r_count + 1'b1;
        end
      end

      // Setting the flag wins over a write-1-to-clear on the same edge.
      if (w_match) begin
        r_flag <= 1'b1;
      end else if (MemWrite && Addr == A_CTRL && WriteData[2]) begin
        r_flag <= 1'b0;
      end

      if (MemWrite && Addr == A_CTRL) begin
        r_en   <= WriteData[0];
        r_auto <= WriteData[1];
      end
      if (MemWrite && Addr == A_CMP) begin
        r_cmp <= WriteData;
      end
      if (MemWrite && Addr == A_GPIO_O) begin
        r_gpio_out <= WriteData[7:0];
      end
    end
  end

  always_comb begin
    ReadData = '0;
    if (w_ram_hit) begin
      ReadData = r_mem[w_idx];
    end else begin
      case (Addr)
        A_GPIO_O: ReadData = {{(width-8){1'b0}}, r_gpio_out};
        A_GPIO_I: ReadData = {{(width-8){1'b0}}, r_sync2};
        A_COUNT:  ReadData = r_count;
        A_CMP:    ReadData = r_cmp;
        A_CTRL:   ReadData = {{(width-3){1'b0}}, r_flag, r_auto, r_en};
        default:  ReadData = '0;
      endcase
    end
  end

  assign gpio_out  = r_gpio_out;
  assign timer_irq = r_flag;

endmodule
